// File: rtl/tiny_yolo_inst_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: word geometry, FSM state
// encodings and status_out field offsets. The config block decodes readback
// with the same offsets.
package tiny_yolo_inst_sequencer_pkg;

  localparam int unsigned InstWidth   = 96;
  localparam int unsigned IdxWidth    = 8;
  localparam int unsigned InstLastBit = 95;

  // Encodings are visible to software through status_out[2:0].
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFetch   = 3'd1,
    StIssue   = 3'd2,
    StWaitEnd = 3'd3,
    StDone    = 3'd4
  } seq_state_e;

  localparam int unsigned StatusStateLsb     = 0;
  localparam int unsigned StatusDoneBit      = 3;
  localparam int unsigned StatusErrWrBusyBit = 4;
  localparam int unsigned StatusErrAddrBit   = 5;
  localparam int unsigned StatusErrSpurBit   = 6;
  localparam int unsigned StatusBusyBit      = 7;
  localparam int unsigned StatusIdxLsb       = 8;
  localparam int unsigned StatusCountLsb     = 16;

endpackage

// File: rtl/tiny_yolo_inst_sequencer_if.sv
// Instruction issue channel between the sequencer (master) and the layer
// controller (slave).
//   inst_out / inst_valid_out : instruction and its valid, driven by sequencer
//   inst_ready_in             : layer controller accepts inst_out
//   layer_end_in              : one-cycle pulse, current layer finished
interface tiny_yolo_inst_sequencer_if
  import tiny_yolo_inst_sequencer_pkg::*;
#(
  parameter int unsigned INST_WIDTH = InstWidth
);
  logic [INST_WIDTH-1:0] inst_out;
  logic                  inst_valid_out;
  logic                  inst_ready_in;
  logic                  layer_end_in;

  modport master (
    output inst_out,
    output inst_valid_out,
    input  inst_ready_in,
    input  layer_end_in
  );

  modport slave (
    input  inst_out,
    input  inst_valid_out,
    output inst_ready_in,
    output layer_end_in
  );
endinterface

// File: rtl/tiny_yolo_inst_ram.sv
// One-write / one-read instruction RAM with a registered read port.
//   aclk, aresetn     : clock, async active-low reset (read register only)
//   clr_in            : synchronous clear of the read register
//   we_in/waddr_in/wdata_in : write port
//   re_in/raddr_in    : read request, data appears on rdata_out next cycle
//   rdata_out         : read register, holds its value while re_in is low
module tiny_yolo_inst_ram #(
  parameter int unsigned DATA_WIDTH = 96,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  clr_in,
  input  logic                  we_in,
  input  logic [ADDR_WIDTH-1:0] waddr_in,
  input  logic [DATA_WIDTH-1:0] wdata_in,
  input  logic                  re_in,
  input  logic [ADDR_WIDTH-1:0] raddr_in,
  output logic [DATA_WIDTH-1:0] rdata_out
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge aclk) begin
    if (we_in) begin
      mem_q[waddr_in] <= wdata_in;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdata_q <= '0;
    end else if (clr_in) begin
      rdata_q <= '0;
    end else if (re_in) begin
      rdata_q <= mem_q[raddr_in];
    end
  end

  assign rdata_out = rdata_q;

endmodule

// File: rtl/tiny_yolo_inst_sequencer.sv
// Instruction sequencer: stores instruction words written via config into a
// local RAM and, on start, replays them one layer at a time to the layer
// controller, waiting for layer_end between instructions.
//   aclk, aresetn  : clock, async active-low reset
//   sreset_in      : sync soft reset (level); RAM contents retained
//   inst_*_in      : instruction write port (data, 32-bit index, strobe)
//   start_in       : program start pulse
//   lc             : issue channel to the layer controller
//   done_out       : program complete (level)
//   busy_out       : replay in progress
//   status_out     : state / flags / idx / layer count readback
module tiny_yolo_inst_sequencer
  import tiny_yolo_inst_sequencer_pkg::*;
#(
  parameter int unsigned INST_WIDTH = InstWidth,
  parameter int unsigned IDX_WIDTH  = IdxWidth,
  parameter int unsigned LAST_BIT   = InstLastBit
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   sreset_in,
  input  logic [INST_WIDTH-1:0]  inst_data_in,
  input  logic [31:0]            inst_addr_in,
  input  logic                   inst_wr_en_in,
  input  logic                   start_in,
  tiny_yolo_inst_sequencer_if.master lc,
  output logic                   done_out,
  output logic                   busy_out,
  output logic [31:0]            status_out
);

  seq_state_e            state_q, state_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [IDX_WIDTH:0]    cnt_q, cnt_d;
  logic                  err_wr_busy_q, err_wr_busy_d;
  logic                  err_addr_q, err_addr_d;
  logic                  err_spur_q, err_spur_d;

  logic [INST_WIDTH-1:0] inst_rdata;
  logic                  addr_oob;
  logic                  wr_busy;
  logic                  ram_we;
  logic                  handshake;
  logic                  is_last;

  assign busy_out  = (state_q == StFetch) || (state_q == StIssue) || (state_q == StWaitEnd);
  assign done_out  = (state_q == StDone);
  assign addr_oob  = |inst_addr_in[31:IDX_WIDTH];
  // Soft reset forces the FSM idle, so a write during it is not a busy write.
  assign wr_busy   = inst_wr_en_in && busy_out && !sreset_in;
  assign ram_we    = inst_wr_en_in && !addr_oob && (!busy_out || sreset_in);
  assign handshake = (state_q == StIssue) && lc.inst_ready_in;
  assign is_last   = inst_rdata[LAST_BIT] || (idx_q == {IDX_WIDTH{1'b1}});

  // The RAM read register doubles as inst_out: loaded only in FETCH, so it
  // stays stable through ISSUE and WAIT_END.
  tiny_yolo_inst_ram #(
    .DATA_WIDTH(INST_WIDTH),
    .ADDR_WIDTH(IDX_WIDTH)
  ) u_inst_ram (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .clr_in    (sreset_in),
    .we_in     (ram_we),
    .waddr_in  (inst_addr_in[IDX_WIDTH-1:0]),
    .wdata_in  (inst_data_in),
    .re_in     (state_q == StFetch),
    .raddr_in  (idx_q),
    .rdata_out (inst_rdata)
  );

  assign lc.inst_out       = inst_rdata;
  assign lc.inst_valid_out = (state_q == StIssue);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    err_wr_busy_d = err_wr_busy_q;
    err_addr_d    = err_addr_q;
    err_spur_d    = err_spur_q;

    case (state_q)
      StIdle, StDone: begin
        if (start_in) begin
          state_d       = StFetch;
          idx_d         = '0;
          cnt_d         = '0;
          err_wr_busy_d = 1'b0;
          err_addr_d    = 1'b0;
          err_spur_d    = 1'b0;
        end
      end
      StFetch: state_d = StIssue;
      StIssue: begin
        if (handshake) begin
          state_d = StWaitEnd;
        end
      end
      StWaitEnd: begin
        if (lc.layer_end_in) begin
          cnt_d = cnt_q + 1'b1;
          if (is_last) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Error events in this cycle win over the clear on start.
    if (inst_wr_en_in && addr_oob) begin
      err_addr_d = 1'b1;
    end
    if (wr_busy) begin
      err_wr_busy_d = 1'b1;
    end
    if (lc.layer_end_in && (state_q != StWaitEnd)) begin
      err_spur_d = 1'b1;
    end

    if (sreset_in) begin
      state_d       = StIdle;
      idx_d         = '0;
      cnt_d         = '0;
      err_wr_busy_d = 1'b0;
      err_addr_d    = 1'b0;
      err_spur_d    = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      cnt_q         <= '0;
      err_wr_busy_q <= 1'b0;
      err_addr_q    <= 1'b0;
      err_spur_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      err_wr_busy_q <= err_wr_busy_d;
      err_addr_q    <= err_addr_d;
      err_spur_q    <= err_spur_d;
    end
  end

  always_comb begin
    status_out                                    = '0;
    status_out[StatusStateLsb +: 3]               = state_q;
    status_out[StatusDoneBit]                     = done_out;
    status_out[StatusErrWrBusyBit]                = err_wr_busy_q;
    status_out[StatusErrAddrBit]                  = err_addr_q;
    status_out[StatusErrSpurBit]                  = err_spur_q;
    status_out[StatusBusyBit]                     = busy_out;
    status_out[StatusIdxLsb +: IDX_WIDTH]         = idx_q;
    status_out[StatusCountLsb +: IDX_WIDTH + 1]   = cnt_q;
  end

endmodule

// File: tb/tb_tiny_yolo_inst_sequencer.sv
module tb_tiny_yolo_inst_sequencer;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        sreset_in = 1'b0;
  logic [95:0] inst_data_in = '0;
  logic [31:0] inst_addr_in = '0;
  logic        inst_wr_en_in = 1'b0;
  logic        start_in = 1'b0;
  logic        done_out;
  logic        busy_out;
  logic [31:0] status_out;

  tiny_yolo_inst_sequencer_if #(.INST_WIDTH(96)) lc_if ();

  tiny_yolo_inst_sequencer dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .sreset_in     (sreset_in),
    .inst_data_in  (inst_data_in),
    .inst_addr_in  (inst_addr_in),
    .inst_wr_en_in (inst_wr_en_in),
    .start_in      (start_in),
    .lc            (lc_if),
    .done_out      (done_out),
    .busy_out      (busy_out),
    .status_out    (status_out)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: program memory and sticky flags.
  logic [95:0] m_mem [256];
  bit          m_err_wr_busy, m_err_addr, m_err_spur;
  int          m_cnt;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // States: 0 idle, 1 fetch, 2 issue, 3 wait_end, 4 done.
  function automatic logic [31:0] exp_status(input int st, input int idx, input int cnt);
    int v;
    v = st;
    if (st == 4) v += 8;
    v += int'(m_err_wr_busy) * 16 + int'(m_err_addr) * 32 + int'(m_err_spur) * 64;
    if (st >= 1 && st <= 3) v += 128;
    v += idx * 256 + cnt * 65536;
    return v;
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [95:0] data, input bit busy);
    inst_wr_en_in = 1'b1;
    inst_addr_in  = addr;
    inst_data_in  = data;
    tick();
    inst_wr_en_in = 1'b0;
    if (addr > 32'd255) m_err_addr = 1'b1;
    if (busy) m_err_wr_busy = 1'b1;
    if (addr <= 32'd255 && !busy) m_mem[addr] = data;
  endtask

  function automatic logic [95:0] rand_word();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic run_program(input int sreset_idx, input bit busy_write, input bit spur_issue,
                             input bit start_write, input logic [95:0] start_wdata);
    int          idx;
    int          k;
    int          d;
    logic [95:0] exp_inst;
    start_in = 1'b1;
    if (start_write) begin
      inst_wr_en_in = 1'b1;
      inst_addr_in  = 32'd0;
      inst_data_in  = start_wdata;
      m_mem[0]      = start_wdata;
    end
    tick();
    start_in      = 1'b0;
    inst_wr_en_in = 1'b0;
    m_err_wr_busy = 0;
    m_err_addr    = 0;
    m_err_spur    = 0;
    m_cnt         = 0;
    idx           = 0;
    check_eq("fetch_status", status_out, exp_status(1, 0, 0));
    for (int n = 0; n < 256; n++) begin
      tick();
      exp_inst = m_mem[idx];
      check_eq("issue_valid", lc_if.inst_valid_out, 1);
      check_eq("issue_inst", lc_if.inst_out, exp_inst);
      check_eq("issue_status", status_out, exp_status(2, idx, m_cnt));
      k = $urandom_range(0, 3);
      if (spur_issue && k == 0) k = 1;
      for (int j = 0; j < k; j++) begin
        if (spur_issue && j == 0) begin
          lc_if.layer_end_in = 1'b1;
          m_err_spur = 1'b1;
        end
        tick();
        lc_if.layer_end_in = 1'b0;
        check_eq("stall_valid", lc_if.inst_valid_out, 1);
        check_eq("stall_inst", lc_if.inst_out, exp_inst);
        check_eq("stall_status", status_out, exp_status(2, idx, m_cnt));
      end
      lc_if.inst_ready_in = 1'b1;
      if (spur_issue && idx == 0) begin
        lc_if.layer_end_in = 1'b1;
        m_err_spur = 1'b1;
      end
      tick();
      lc_if.inst_ready_in = 1'b0;
      lc_if.layer_end_in  = 1'b0;
      check_eq("accept_valid", lc_if.inst_valid_out, 0);
      check_eq("wait_status", status_out, exp_status(3, idx, m_cnt));
      d = $urandom_range(0, 4);
      if (busy_write && d == 0) d = 1;
      for (int j = 0; j < d; j++) begin
        if (busy_write && j == 0) begin
          inst_wr_en_in = 1'b1;
          inst_addr_in  = (idx + 1) % 256;
          inst_data_in  = rand_word();
          m_err_wr_busy = 1'b1;
        end
        tick();
        inst_wr_en_in = 1'b0;
        check_eq("wait_hold_status", status_out, exp_status(3, idx, m_cnt));
      end
      if (idx == sreset_idx) begin
        sreset_in = 1'b1;
        tick();
        sreset_in     = 1'b0;
        m_err_wr_busy = 0;
        m_err_addr    = 0;
        m_err_spur    = 0;
        m_cnt         = 0;
        check_eq("sreset_status", status_out, 0);
        check_eq("sreset_valid", lc_if.inst_valid_out, 0);
        check_eq("sreset_inst", lc_if.inst_out, 0);
        check_eq("sreset_done", done_out, 0);
        return;
      end
      lc_if.layer_end_in = 1'b1;
      tick();
      lc_if.layer_end_in = 1'b0;
      m_cnt++;
      if (exp_inst[95] || idx == 255) begin
        check_eq("done_level", done_out, 1);
        check_eq("done_status", status_out, exp_status(4, idx, m_cnt));
        return;
      end
      idx++;
      check_eq("next_fetch_status", status_out, exp_status(1, idx, m_cnt));
    end
  endtask

  initial begin
    logic [95:0] w;
    int          len;
    lc_if.inst_ready_in = 1'b0;
    lc_if.layer_end_in  = 1'b0;
    m_err_wr_busy = 0;
    m_err_addr    = 0;
    m_err_spur    = 0;
    m_cnt         = 0;
    for (int i = 0; i < 256; i++) m_mem[i] = '0;

    #1;
    check_eq("rst_status", status_out, 0);
    check_eq("rst_inst", lc_if.inst_out, 0);
    check_eq("rst_valid", lc_if.inst_valid_out, 0);
    check_eq("rst_done", done_out, 0);
    check_eq("rst_busy", busy_out, 0);
    #11;
    aresetn = 1'b1;
    tick();

    // Spurious layer_end in IDLE: flag set, state stays idle.
    lc_if.layer_end_in = 1'b1;
    tick();
    lc_if.layer_end_in = 1'b0;
    m_err_spur = 1'b1;
    check_eq("spur_idle", status_out, exp_status(0, 0, 0));

    // Three-instruction program, last marked by bit 95.
    do_write(32'd0, 96'h1, 0);
    do_write(32'd1, 96'h2, 0);
    w = 96'h3;
    w[95] = 1'b1;
    do_write(32'd2, w, 0);
    run_program(-1, 0, 0, 0, '0);
    check_eq("count3", status_out[24:16], 3);

    // Out-of-range write in DONE; spurious end in DONE.
    do_write(32'h100, rand_word(), 0);
    check_eq("oob_status", status_out, exp_status(4, 2, 3));
    do_write(32'h8000_0001, rand_word(), 0);
    lc_if.layer_end_in = 1'b1;
    tick();
    lc_if.layer_end_in = 1'b0;
    m_err_spur = 1'b1;
    check_eq("spur_done", status_out, exp_status(4, 2, 3));

    // Replay with busy write and spurious ends; RAM must be unchanged.
    run_program(-1, 1, 1, 0, '0);

    // Soft reset mid-program, then full replay from idx0.
    run_program(1, 0, 0, 0, '0);
    run_program(-1, 0, 0, 0, '0);

    // Write coinciding with start commits before the first fetch.
    run_program(-1, 0, 0, 1, rand_word() & ~(96'h1 << 95));

    // Random programs with the last bit at a random position.
    for (int r = 0; r < 4; r++) begin
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) begin
        w = rand_word();
        w[95] = (i == len - 1);
        do_write(i, w, 0);
      end
      run_program(-1, r[0], r[1], 0, '0);
    end

    // Full 256-entry program without a last marker.
    for (int i = 0; i < 256; i++) begin
      w = rand_word();
      w[95] = 1'b0;
      do_write(i, w, 0);
    end
    run_program(-1, 0, 0, 0, '0);
    check_eq("count256", status_out[24:16], 256);

    // Async reset while issuing.
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    tick();
    #2;
    aresetn = 1'b0;
    #1;
    check_eq("arst_status", status_out, 0);
    check_eq("arst_valid", lc_if.inst_valid_out, 0);
    check_eq("arst_inst", lc_if.inst_out, 0);
    check_eq("arst_busy", busy_out, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    tick();
    tick();
    check_eq("arst_stays_idle", status_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
